// File: rtl/guess_evaluator.sv
// Guess evaluator: holds the armed secret and guess budget, and compares each confirmed guess
// against the secret one digit per cycle, most significant active digit first. It produces
// too-high / too-low / correct hints, counts down the remaining guesses and flags win or loss.
module guess_evaluator #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned GUESS_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic [DIGIT_W-1:0] secret_digit_1,
    input  logic [DIGIT_W-1:0] secret_digit_2,
    input  logic [DIGIT_W-1:0] secret_digit_3,
    input  logic [1:0]         max_digits,
    input  logic [GUESS_W-1:0] max_guesses,
    input  logic [DIGIT_W-1:0] guess_digit_1,
    input  logic [DIGIT_W-1:0] guess_digit_2,
    input  logic [DIGIT_W-1:0] guess_digit_3,
    input  logic               confirm,
    output logic [GUESS_W-1:0] guesses_left,
    output logic               hint_high,
    output logic               hint_low,
    output logic               correct,
    output logic               game_won,
    output logic               game_lost,
    output logic               busy,
    output logic               playing
);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StCompare,
        StResult,
        StWon,
        StLost
    } state_e;

    typedef enum logic [1:0] {
        CmpHigh,
        CmpLow,
        CmpEq
    } cmp_e;

    localparam logic [GUESS_W-1:0] GuessOne = {{(GUESS_W-1){1'b0}}, 1'b1};

    state_e             state_q;
    cmp_e               cmp_q;
    logic               confirm_q;
    logic [1:0]         max_digits_q;
    logic [1:0]         idx_q;
    logic [DIGIT_W-1:0] secret1_q, secret2_q, secret3_q;
    logic [DIGIT_W-1:0] guess1_q, guess2_q, guess3_q;
    logic [GUESS_W-1:0] guesses_left_q;
    logic               hint_high_q, hint_low_q, correct_q;
    logic               game_won_q, game_lost_q;
    logic               busy_q, playing_q;

    logic               confirm_edge;
    logic [DIGIT_W-1:0] guess_cur;
    logic [DIGIT_W-1:0] secret_cur;

    assign confirm_edge = confirm & ~confirm_q;

    // Select the digit pair addressed by the current compare index (3 = hundreds, 1 = ones).
    always_comb begin
        guess_cur  = guess1_q;
        secret_cur = secret1_q;
        case (idx_q)
            2'd3: begin
                guess_cur  = guess3_q;
                secret_cur = secret3_q;
            end
            2'd2: begin
                guess_cur  = guess2_q;
                secret_cur = secret2_q;
            end
            default: begin
                guess_cur  = guess1_q;
                secret_cur = secret1_q;
            end
        endcase
    end

    // Confirm edge detector history; runs in every state so a held level never re-triggers.
    always_ff @(posedge clk) begin
        if (reset) begin
            confirm_q <= 1'b0;
        end else begin
            confirm_q <= confirm;
        end
    end

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cmp_q          <= CmpEq;
            max_digits_q   <= 2'd1;
            idx_q          <= 2'd1;
            secret1_q      <= '0;
            secret2_q      <= '0;
            secret3_q      <= '0;
            guess1_q       <= '0;
            guess2_q       <= '0;
            guess3_q       <= '0;
            guesses_left_q <= '0;
            hint_high_q    <= 1'b0;
            hint_low_q     <= 1'b0;
            correct_q      <= 1'b0;
            game_won_q     <= 1'b0;
            game_lost_q    <= 1'b0;
            busy_q         <= 1'b0;
            playing_q      <= 1'b0;
        end else if (new_game) begin
            // Reload overrides any evaluation in flight; a coincident confirm edge is dropped.
            state_q        <= StPlay;
            secret1_q      <= secret_digit_1;
            secret2_q      <= secret_digit_2;
            secret3_q      <= secret_digit_3;
            max_digits_q   <= (max_digits == 2'd0) ? 2'd1 : max_digits;
            guesses_left_q <= (max_guesses == '0) ? GuessOne : max_guesses;
            hint_high_q    <= 1'b0;
            hint_low_q     <= 1'b0;
            correct_q      <= 1'b0;
            game_won_q     <= 1'b0;
            game_lost_q    <= 1'b0;
            busy_q         <= 1'b0;
            playing_q      <= 1'b1;
        end else begin
            case (state_q)
                StPlay: begin
                    if (confirm_edge) begin
                        guess1_q <= guess_digit_1;
                        guess2_q <= guess_digit_2;
                        guess3_q <= guess_digit_3;
                        idx_q    <= max_digits_q;
                        state_q  <= StCompare;
                        busy_q   <= 1'b1;
                    end
                end
                StCompare: begin
                    if (guess_cur > secret_cur) begin
                        cmp_q   <= CmpHigh;
                        state_q <= StResult;
                    end else if (guess_cur < secret_cur) begin
                        cmp_q   <= CmpLow;
                        state_q <= StResult;
                    end else if (idx_q == 2'd1) begin
                        cmp_q   <= CmpEq;
                        state_q <= StResult;
                    end else begin
                        idx_q <= idx_q - 2'd1;
                    end
                end
                StResult: begin
                    hint_high_q <= (cmp_q == CmpHigh);
                    hint_low_q  <= (cmp_q == CmpLow);
                    correct_q   <= (cmp_q == CmpEq);
                    busy_q      <= 1'b0;
                    if (cmp_q == CmpEq) begin
                        game_won_q <= 1'b1;
                        playing_q  <= 1'b0;
                        state_q    <= StWon;
                    end else if (guesses_left_q <= GuessOne) begin
                        // Last guess used up; saturate at zero.
                        guesses_left_q <= '0;
                        game_lost_q    <= 1'b1;
                        playing_q      <= 1'b0;
                        state_q        <= StLost;
                    end else begin
                        guesses_left_q <= guesses_left_q - GuessOne;
                        state_q        <= StPlay;
                    end
                end
                default: begin
                    // Idle, Won and Lost hold everything until new_game or reset.
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign guesses_left = guesses_left_q;
    assign hint_high    = hint_high_q;
    assign hint_low     = hint_low_q;
    assign correct      = correct_q;
    assign game_won     = game_won_q;
    assign game_lost    = game_lost_q;
    assign busy         = busy_q;
    assign playing      = playing_q;

endmodule

// File: tb/tb_guess_evaluator.sv
// Directed self-checking bench for guess_evaluator.
module tb_guess_evaluator;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic [3:0] secret_digit_1, secret_digit_2, secret_digit_3;
    logic [1:0] max_digits;
    logic [2:0] max_guesses;
    logic [3:0] guess_digit_1, guess_digit_2, guess_digit_3;
    logic       confirm;
    logic [2:0] guesses_left;
    logic       hint_high, hint_low, correct, game_won, game_lost, busy, playing;

    int n_cmp = 0;
    int n_err = 0;

    guess_evaluator #(
        .DIGIT_W(4),
        .GUESS_W(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .new_game      (new_game),
        .secret_digit_1(secret_digit_1),
        .secret_digit_2(secret_digit_2),
        .secret_digit_3(secret_digit_3),
        .max_digits    (max_digits),
        .max_guesses   (max_guesses),
        .guess_digit_1 (guess_digit_1),
        .guess_digit_2 (guess_digit_2),
        .guess_digit_3 (guess_digit_3),
        .confirm       (confirm),
        .guesses_left  (guesses_left),
        .hint_high     (hint_high),
        .hint_low      (hint_low),
        .correct       (correct),
        .game_won      (game_won),
        .game_lost     (game_lost),
        .busy          (busy),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vector {gl[2:0], high, low, correct, won, lost, busy, playing}.
    function automatic int outs();
        return int'({guesses_left, hint_high, hint_low, correct, game_won, game_lost, busy,
                     playing});
    endfunction

    function automatic int pack(input int gl, input bit hi, input bit lo, input bit co,
                                input bit wo, input bit lt, input bit bs, input bit pl);
        return (gl << 7) | (int'(hi) << 6) | (int'(lo) << 5) | (int'(co) << 4) |
               (int'(wo) << 3) | (int'(lt) << 2) | (int'(bs) << 1) | int'(pl);
    endfunction

    task automatic start_game(input logic [3:0] s3, input logic [3:0] s2, input logic [3:0] s1,
                              input logic [1:0] md, input logic [2:0] mg);
        secret_digit_3 = s3;
        secret_digit_2 = s2;
        secret_digit_1 = s1;
        max_digits     = md;
        max_guesses    = mg;
        new_game       = 1'b1;
        tick();
        new_game       = 1'b0;
    endtask

    // Submit one guess and check that busy drops exactly k+1 cycles after the edge.
    task automatic do_guess(input string tag, input logic [3:0] g3, input logic [3:0] g2,
                            input logic [3:0] g1, input int k);
        int n;
        guess_digit_3 = g3;
        guess_digit_2 = g2;
        guess_digit_1 = g1;
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 10);
        check({tag, "_latency"}, n, k + 1);
    endtask

    initial begin
        reset = 1'b1;
        new_game = 1'b0;
        confirm = 1'b0;
        secret_digit_1 = '0;
        secret_digit_2 = '0;
        secret_digit_3 = '0;
        max_digits = 2'd0;
        max_guesses = 3'd0;
        guess_digit_1 = '0;
        guess_digit_2 = '0;
        guess_digit_3 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_outs", outs(), 0);

        // Confirm in IDLE does nothing.
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
        check("idle_confirm", outs(), 0);

        // Secret 4-7-2, three digits, three guesses.
        start_game(4'd4, 4'd7, 4'd2, 2'd3, 3'd3);
        check("ng_outs", outs(), pack(3, 0, 0, 0, 0, 0, 0, 1));
        do_guess("g500", 4'd5, 4'd0, 4'd0, 1);
        check("g500_outs", outs(), pack(2, 1, 0, 0, 0, 0, 0, 1));
        do_guess("g471", 4'd4, 4'd7, 4'd1, 3);
        check("g471_outs", outs(), pack(1, 0, 1, 0, 0, 0, 0, 1));
        do_guess("g472", 4'd4, 4'd7, 4'd2, 3);
        check("g472_outs", outs(), pack(1, 0, 0, 1, 1, 0, 0, 0));
        // Further edges in WON are ignored.
        for (int i = 0; i < 2; i++) begin
            confirm = 1'b1;
            tick();
            confirm = 1'b0;
            tick();
        end
        tick();
        check("won_hold", outs(), pack(1, 0, 0, 1, 1, 0, 0, 0));

        // One active digit: upper digits must be ignored.
        start_game(4'd0, 4'd0, 4'd9, 2'd1, 3'd2);
        check("ng2_outs", outs(), pack(2, 0, 0, 0, 0, 0, 0, 1));
        do_guess("g993", 4'd9, 4'd9, 4'd3, 1);
        check("g993_outs", outs(), pack(1, 0, 1, 0, 0, 0, 0, 1));
        do_guess("g053", 4'd0, 4'd5, 4'd3, 1);
        check("g053_outs", outs(), pack(0, 0, 1, 0, 0, 1, 0, 0));
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
        tick();
        check("lost_hold", outs(), pack(0, 0, 1, 0, 0, 1, 0, 0));

        // Zero clamps, and a confirm edge coincident with new_game is discarded.
        confirm = 1'b1;
        start_game(4'd2, 4'd2, 4'd5, 2'd0, 3'd0);
        check("clamp_ng", outs(), pack(1, 0, 0, 0, 0, 0, 0, 1));
        tick();
        check("ng_edge_dropped", outs(), pack(1, 0, 0, 0, 0, 0, 0, 1));
        confirm = 1'b0;
        tick();
        do_guess("clamp_g", 4'd9, 4'd9, 4'd1, 1);
        check("clamp_outs", outs(), pack(0, 0, 1, 0, 0, 1, 0, 0));

        // Held confirm gives a single evaluation.
        start_game(4'd1, 4'd2, 4'd3, 2'd3, 3'd5);
        guess_digit_3 = 4'd9;
        guess_digit_2 = 4'd0;
        guess_digit_1 = 4'd0;
        confirm = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        confirm = 1'b0;
        tick();
        check("hold_outs", outs(), pack(4, 1, 0, 0, 0, 0, 0, 1));

        // new_game during COMPARE: reload to PLAY, the aborted guess never lands.
        guess_digit_3 = 4'd1;
        guess_digit_2 = 4'd2;
        guess_digit_1 = 4'd0;
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        tick();
        check("mid_busy", int'(busy), 1);
        start_game(4'd1, 4'd2, 4'd3, 2'd3, 3'd6);
        check("mid_ng", outs(), pack(6, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 4; i++) tick();
        check("mid_after", outs(), pack(6, 0, 0, 0, 0, 0, 0, 1));

        // reset wins over new_game.
        reset = 1'b1;
        start_game(4'd3, 4'd3, 4'd3, 2'd3, 3'd7);
        reset = 1'b0;
        check("rst_ng", outs(), 0);
        tick();
        check("rst_ng_after", outs(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
